sev_seg_scan_driver: RTL and testbench
======================================

# sev_seg_scan_driver

Time-multiplexed 4-digit seven-segment scan driver sitting directly downstream of the digit-value register stage. It consumes the four 4-bit digit values (value1..value4) that stage produces and drives the board's shared active-low cathodes and per-digit active-low anodes. It snapshots all four digits once per frame so a frame never shows mixed old and new values. It also inserts a dark interval between digits to suppress ghosting, and supports optional leading-zero blanking and per-digit decimal points.

## Interface
- REFRESH_CNT, 100000: clk cycles each digit is lit (SHOW phase); must be ≥1.
- BLANK_CNT, 1000: clk cycles all digits are dark before each SHOW (BLANK phase); must be ≥1.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset. It is asynchronous and active-low.
- en  in  1  scan enable; low forces display dark.
- value1  in  4  digit 0 (rightmost, an[0]) hex value.
- value2  in  4  digit 1 (an[1]) hex value.
- value3  in  4  digit 2 (an[2]) hex value.
- value4  in  4  digit 3 (leftmost, an[3]) hex value.
- dp_mask  in  4  bit i=1 lights decimal point of digit i.
- lz_blank  in  1  1 enables leading-zero blanking.
- an  out  4  anode enables, active-low, one-hot-low when lit.
- seg  out  7  cathodes, active-low, seg[0]=a … seg[6]=g.
- dp  out  1  decimal-point cathode, active-low.
- frame_done  out  1  one-cycle pulse at end of each full 4-digit frame.

## Operation
- The FSM has three states: OFF, BLANK and SHOW. Separate regs hold the digit index idx[1:0], a phase counter cnt sized $clog2(max(REFRESH_CNT,BLANK_CNT)+1), and the snapshot regs s1..s4 and sdp[3:0].
- OFF:
  - Outputs are dark (an=4'hF, seg=7'h7F, dp=1); idx=0 and cnt=0.
  - When en=1, go to BLANK and snapshot value1..4/dp_mask into s1..s4/sdp.
- BLANK:
  - Outputs are dark.
  - After BLANK_CNT cycles, go to SHOW with cnt cleared.
- SHOW:
  - an[idx]=0 and all other anodes=1.
  - seg=decode(s[idx]); dp=~sdp[idx].
  - After REFRESH_CNT cycles:
    - If idx<3: idx+1, go to BLANK.
    - If idx=3: idx wraps to 0, go to BLANK, take a new snapshot, and pulse frame_done.
- Snapshots are taken only on OFF→BLANK and on the idx 3→0 wrap. Input changes at any other time are invisible until the next snapshot.
- Leading-zero blanking (lz_blank, sampled with the snapshot), evaluated on snapshot values:
  - digit3 is blanked if s4=0.
  - digit2 is blanked if s4=0 and s3=0.
  - digit1 is blanked if s4=s3=s2=0.
  - digit0 is never blanked.
- A blanked digit still occupies its BLANK and SHOW time, but an stays 4'hF and dp stays 1 throughout its SHOW.
- decode, values 0..F → seg[6:0]:
  - 0 to 3: 1000000, 1111001, 0100100, 0110000
  - 4 to 7: 0011001, 0010010, 0000010, 1111000
  - 8 to b: 0000000, 0010000, 0001000, 0000011
  - C to F: 1000110, 0100001, 0000110, 0001110
- en=0 in any state: next edge goes to OFF, outputs go dark, idx/cnt clear, and frame_done is suppressed even if the wrap coincides.

## Timing
- Reset values: an=4'hF, seg=7'h7F, dp=1, frame_done=0, state=OFF, idx=0, cnt=0, s1..s4=0, sdp=0.
- All outputs are registered and change on the same edge as the state transition; no combinational input→output path exists.
- Each digit slot lasts exactly BLANK_CNT+REFRESH_CNT cycles. A frame lasts 4·(BLANK_CNT+REFRESH_CNT) cycles.
- frame_done is high for exactly the one cycle following the last SHOW cycle of digit 3, i.e. the first BLANK cycle of digit 0. It repeats every frame period.
- With en rising at edge k, the first BLANK cycle is k+1 and digit 0 lights at k+1+BLANK_CNT.
- Asserting rst_n low mid-frame forces the reset values immediately, without waiting for a clock edge. After release, the block starts from OFF.
- At no cycle is more than one anode low. Every anode change passes through at least BLANK_CNT cycles with an=4'hF.

## Test plan
- Reset/idle:
  - Stimulus: REFRESH_CNT=4, BLANK_CNT=2; rst_n low then released with en=0.
  - Required: an=F, seg=7F, dp=1 indefinitely, and frame_done never pulses.
- Scan order:
  - Stimulus: values 1,2,3,4 (value1..4), dp_mask=0, en=1.
  - Required:
    - an follows F,F,E,E,E,E,F,F,D,D,D,D,… with seg 1111001 (digit 1) while an=E and seg 0110011? is not expected; instead seg=0011001 (digit 4) while an=7.
    - frame_done pulses every 24 cycles.
- Snapshot isolation:
  - Stimulus: change value1 from 1 to 8 while idx=2.
  - Required: digit 0 shows 1111001 until after the next frame_done, then 0000000.
- Leading-zero:
  - Stimulus: lz_blank=1, values 5,0,0,0 (value1..4).
  - Required: only an=E is ever driven low, with seg=0010010. Changing value3 to 7 causes an=B to show 1111000 and an=D to show 1000000 from the next frame.
- Decimal point / en drop:
  - Stimulus: dp_mask=4'b0100.
  - Required: dp=0 only while an=B.
  - Stimulus: deassert en on the frame_done cycle.
  - Required: dark on the next edge, no pulse, and restart at digit 0 when en is reasserted.
- Async reset:
  - Stimulus: pull rst_n low mid-SHOW.
  - Required: an=F, seg=7F, dp=1 immediately, before the next clk edge.

Source files
------------

// File: rtl/sev_seg_scan_driver_if.sv
// Digit-value inputs and display-side outputs of the seven-segment scan driver.
// The master drives the digit values and controls; the slave is the scan driver.
interface sev_seg_scan_driver_if;
    logic       en;
    logic [3:0] value1;
    logic [3:0] value2;
    logic [3:0] value3;
    logic [3:0] value4;
    logic [3:0] dp_mask;
    logic       lz_blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    modport master (
        output en, value1, value2, value3, value4, dp_mask, lz_blank,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  en, value1, value2, value3, value4, dp_mask, lz_blank,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/sev_seg_scan_driver.sv
// Time-multiplexed 4-digit seven-segment scan driver with per-frame snapshot,
// inter-digit dark interval, leading-zero blanking and decimal points.
module sev_seg_scan_driver #(
    parameter int unsigned REFRESH_CNT = 100000,
    parameter int unsigned BLANK_CNT   = 1000
) (
    input logic                  clk,
    input logic                  rst_n,
    sev_seg_scan_driver_if.slave bus_if
);
    localparam int unsigned MAXC = (REFRESH_CNT > BLANK_CNT) ? REFRESH_CNT : BLANK_CNT;
    localparam int unsigned CW   = $clog2(MAXC + 1);

    localparam logic [1:0] ST_OFF   = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0][3:0] s_q, s_d;
    logic [3:0]      sdp_q, sdp_d;
    logic            slz_q, slz_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            fd_q, fd_d;
    logic            snap;
    logic [3:0]      blk;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'b1000000;
            4'h1: r = 7'b1111001;
            4'h2: r = 7'b0100100;
            4'h3: r = 7'b0110000;
            4'h4: r = 7'b0011001;
            4'h5: r = 7'b0010010;
            4'h6: r = 7'b0000010;
            4'h7: r = 7'b1111000;
            4'h8: r = 7'b0000000;
            4'h9: r = 7'b0010000;
            4'hA: r = 7'b0001000;
            4'hB: r = 7'b0000011;
            4'hC: r = 7'b1000110;
            4'hD: r = 7'b0100001;
            4'hE: r = 7'b0000110;
            default: r = 7'b0001110;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        fd_d    = 1'b0;
        snap    = 1'b0;
        case (state_q)
            ST_OFF: begin
                idx_d = '0;
                cnt_d = '0;
                if (bus_if.en) begin
                    state_d = ST_BLANK;
                    snap    = 1'b1;
                end
            end
            ST_BLANK: begin
                if (cnt_q == CW'(BLANK_CNT - 1)) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SHOW: begin
                if (cnt_q == CW'(REFRESH_CNT - 1)) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        snap = 1'b1;
                        fd_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_OFF;
        endcase

        // Disable overrides everything, including a coincident frame wrap.
        if (!bus_if.en) begin
            state_d = ST_OFF;
            idx_d   = '0;
            cnt_d   = '0;
            fd_d    = 1'b0;
            snap    = 1'b0;
        end

        s_d   = s_q;
        sdp_d = sdp_q;
        slz_d = slz_q;
        if (snap) begin
            s_d   = {bus_if.value4, bus_if.value3, bus_if.value2, bus_if.value1};
            sdp_d = bus_if.dp_mask;
            slz_d = bus_if.lz_blank;
        end

        blk[0] = 1'b0;
        blk[1] = slz_d && (s_d[3] == 4'h0) && (s_d[2] == 4'h0) && (s_d[1] == 4'h0);
        blk[2] = slz_d && (s_d[3] == 4'h0) && (s_d[2] == 4'h0);
        blk[3] = slz_d && (s_d[3] == 4'h0);

        // Outputs are derived from next-state values so they register on the transition edge.
        an_d  = '1;
        seg_d = '1;
        dp_d  = 1'b1;
        if (state_d == ST_SHOW && !blk[idx_d]) begin
            an_d[idx_d] = 1'b0;
            seg_d       = decode(s_d[idx_d]);
            dp_d        = ~sdp_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            idx_q   <= '0;
            cnt_q   <= '0;
            s_q     <= '0;
            sdp_q   <= '0;
            slz_q   <= 1'b0;
            an_q    <= '1;
            seg_q   <= '1;
            dp_q    <= 1'b1;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            sdp_q   <= sdp_d;
            slz_q   <= slz_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            fd_q    <= fd_d;
        end
    end

    assign bus_if.an         = an_q;
    assign bus_if.seg        = seg_q;
    assign bus_if.dp         = dp_q;
    assign bus_if.frame_done = fd_q;
endmodule

// File: tb/tb_sev_seg_scan_driver.sv
// Scoreboard bench for sev_seg_scan_driver: a frame-position model predicts
// every cycle's outputs, which are compared on the falling clock edge.
module tb_sev_seg_scan_driver;
    localparam int unsigned R     = 4;
    localparam int unsigned B     = 2;
    localparam int          SLOT  = R + B;
    localparam int          FRAME = 4 * SLOT;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    sev_seg_scan_driver_if bus_if();

    sev_seg_scan_driver #(.REFRESH_CNT(R), .BLANK_CNT(B)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bus_if.slave)
    );

    always #5 clk = ~clk;

    logic [6:0] SEG_TBL [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    exp_t       sb[$];
    int         t = 0;
    logic [3:0] sv [4];
    logic [3:0] sdp = '0;
    logic       slz = 1'b0;

    // Predictor: t counts cycles since the scan started; frame position follows from t.
    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        int   pos, slot;
        logic hide;
        if (!rst_n) begin
            t = 0;
            sb.delete();
        end else begin
            if (!bus_if.en) t = 0;
            else begin
                t = t + 1;
                if ((t - 1) % FRAME == 0) begin
                    sv[0] = bus_if.value1; sv[1] = bus_if.value2;
                    sv[2] = bus_if.value3; sv[3] = bus_if.value4;
                    sdp = bus_if.dp_mask;
                    slz = bus_if.lz_blank;
                end
            end
            e.fd  = (t > 1) && ((t - 1) % FRAME == 0);
            e.an  = 4'hF;
            e.seg = 7'h7F;
            e.dp  = 1'b1;
            if (t > 0) begin
                pos  = (t - 1) % FRAME;
                slot = pos / SLOT;
                if (pos % SLOT >= B) begin
                    hide = slz && ((slot == 3 && sv[3] == 0) ||
                                   (slot == 2 && sv[3] == 0 && sv[2] == 0) ||
                                   (slot == 1 && sv[3] == 0 && sv[2] == 0 && sv[1] == 0));
                    if (!hide) begin
                        e.an       = 4'hF;
                        e.an[slot] = 1'b0;
                        e.seg      = SEG_TBL[sv[slot]];
                        e.dp       = ~sdp[slot];
                    end
                end
            end
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            if ({bus_if.an, bus_if.seg, bus_if.dp, bus_if.frame_done} !== e) begin
                miscompares++;
                $display("FAIL scoreboard t=%0d: got an=%h seg=%b dp=%b fd=%b, expected an=%h seg=%b dp=%b fd=%b",
                         t, bus_if.an, bus_if.seg, bus_if.dp, bus_if.frame_done,
                         e.an, e.seg, e.dp, e.fd);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_vals(input logic [3:0] a, b, c, d);
        bus_if.value1 = a; bus_if.value2 = b; bus_if.value3 = c; bus_if.value4 = d;
    endtask

    task automatic test_reset();
        int pulses = 0;
        bus_if.en = 1'b0; bus_if.dp_mask = '0; bus_if.lz_blank = 1'b0;
        set_vals(4'h9, 4'h9, 4'h9, 4'h9);
        rst_n = 1'b0;
        cycles(3);
        vectors++;
        if ({bus_if.an, bus_if.seg, bus_if.dp, bus_if.frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_state: got an=%h seg=%b dp=%b fd=%b, expected an=f seg=1111111 dp=1 fd=0",
                     bus_if.an, bus_if.seg, bus_if.dp, bus_if.frame_done);
        end
        rst_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (bus_if.frame_done) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL idle_no_pulse: got %0d frame_done pulses, expected 0", pulses);
        end
    endtask

    task automatic test_scan_order();
        int pulses = 0;
        set_vals(4'h1, 4'h2, 4'h3, 4'h4);
        bus_if.en = 1'b1;
        repeat (2 * FRAME + 2) begin
            @(negedge clk);
            if (bus_if.frame_done) pulses++;
        end
        vectors++;
        if (pulses !== 2) begin
            miscompares++;
            $display("FAIL frame_pulse_count: got %0d pulses, expected 2", pulses);
        end
    endtask

    task automatic wait_an(input logic [3:0] want, input string name);
        int n = 0;
        while (bus_if.an !== want && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (bus_if.an !== want) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got an=%h, expected an=%h within %0d cycles", name, bus_if.an, want, 4 * FRAME);
        end
    endtask

    task automatic test_snapshot();
        wait_an(4'hB, "snapshot");
        bus_if.value1 = 4'h8;
        cycles(2 * FRAME + 3);
    endtask

    task automatic test_leading_zero();
        bus_if.en = 1'b0;
        cycles(2);
        bus_if.lz_blank = 1'b1;
        set_vals(4'h5, 4'h0, 4'h0, 4'h0);
        bus_if.en = 1'b1;
        cycles(2 * FRAME + 5);
        bus_if.value3 = 4'h7;
        cycles(2 * FRAME + 3);
    endtask

    task automatic test_dp_en_drop();
        int n = 0;
        bus_if.en = 1'b0;
        cycles(2);
        bus_if.lz_blank = 1'b0;
        bus_if.dp_mask = 4'b0100;
        set_vals(4'h1, 4'h2, 4'h3, 4'h4);
        bus_if.en = 1'b1;
        cycles(FRAME + 3);
        while (bus_if.frame_done !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus_if.frame_done !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_frame_done_timeout: got fd=%b, expected 1", bus_if.frame_done);
        end
        bus_if.en = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus_if.an, bus_if.frame_done} !== {4'hF, 1'b0}) begin
            miscompares++;
            $display("FAIL en_drop_dark: got an=%h fd=%b, expected an=f fd=0", bus_if.an, bus_if.frame_done);
        end
        cycles(4);
        bus_if.en = 1'b1;
        cycles(FRAME + 3);
    endtask

    task automatic test_async_reset();
        wait_an(4'hE, "async");
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus_if.an, bus_if.seg, bus_if.dp, bus_if.frame_done} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL async_reset: got an=%h seg=%b dp=%b fd=%b, expected an=f seg=1111111 dp=1 fd=0",
                     bus_if.an, bus_if.seg, bus_if.dp, bus_if.frame_done);
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(FRAME + 3);
    endtask

    initial begin
        test_reset();
        test_scan_order();
        test_snapshot();
        test_leading_zero();
        test_dp_en_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
